bw_io_impctl_ddr_dncal_fsm: RTL and testbench

- Calibration sequencer for the DDR impedance-control pull-down comparator slice.
- Drives the slice's 8-bit pull-down code, its output enable and its sample strobe, and reads back the registered "above" comparator result.
- Runs a successive-approximation (SAR) search to find the initial code, then optionally tracks drift with a filtered ±1 up/down stepper.
- Sits between the impctl top-level control and the dn comparator slice; the final code is forwarded to the DDR pad pull-down drivers.

---
 rtl/bw_io_impctl_ddr_dncal_fsm_pkg.sv | 28 ++
 rtl/bw_io_impctl_ddr_dncal_fsm_if.sv | 26 ++
 rtl/bw_io_impctl_ddr_dncal_fsm_updn_filt.sv | 63 ++++++
 rtl/bw_io_impctl_ddr_dncal_fsm.sv | 198 +++++++++++++++++++
 tb/tb_bw_io_impctl_ddr_dncal_fsm.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/bw_io_impctl_ddr_dncal_fsm_pkg.sv
// Shared definitions for the DDR impctl calibration FSMs.
// Used by the pull-down (cbd) sequencer and the future pull-up one.
package bw_io_impctl_defs;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETTLE    = 3'd1,
      ST_STROBE    = 3'd2,
      ST_WAIT      = 3'd3,
      ST_DECIDE    = 3'd4,
      ST_TRACK_CHK = 3'd5
   } state_e;

   typedef enum logic {
      MODE_SAR   = 1'b0,
      MODE_TRACK = 1'b1
   } mode_e;

   localparam int SETTLE_CYC_DEF = 16;
   localparam int SAMPLE_LAT_DEF = 3;
   localparam int FILT_N_DEF     = 4;

   // Width of a counter that must hold values 0..n.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bw_io_impctl_ddr_dncal_fsm_if.sv
// Sequencer <-> comparator slice bundle: code, enable, strobe
// going out and the registered "above" result coming back.
interface bw_io_impctl_ddr_dncal_fsm_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] cbd;
   logic             oe;
   logic             sclk;
   logic             above;

   modport master (
      output cbd,
      output oe,
      output sclk,
      input  above
   );

   modport slave (
      input  cbd,
      input  oe,
      input  sclk,
      output above
   );

endinterface

// File: rtl/bw_io_impctl_ddr_dncal_fsm_updn_filt.sv
// Up/down drift filter: FILT_N consecutive same-direction
// samples produce one step pulse, then both counters restart.
module bw_io_impctl_updn_filt
   import bw_io_impctl_defs::*;
#(
   parameter int FILT_N = FILT_N_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic sample_stb,
   input  logic above,
   output logic step_up,
   output logic step_dn
);

   localparam int CW = cnt_w(FILT_N);

   logic [CW-1:0] up_q, up_d;
   logic [CW-1:0] dn_q, dn_d;

   // Count runs of same-direction samples; a run of FILT_N fires a step.
   always_comb begin
      up_d    = up_q;
      dn_d    = dn_q;
      step_up = 1'b0;
      step_dn = 1'b0;
      if (clr) begin
         up_d = '0;
         dn_d = '0;
      end else if (sample_stb) begin
         if (above) begin
            dn_d = '0;
            if (up_q == CW'(FILT_N - 1)) begin
               step_up = 1'b1;
               up_d    = '0;
            end else begin
               up_d = up_q + CW'(1);
            end
         end else begin
            up_d = '0;
            if (dn_q == CW'(FILT_N - 1)) begin
               step_dn = 1'b1;
               dn_d    = '0;
            end else begin
               dn_d = dn_q + CW'(1);
            end
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         up_q <= '0;
         dn_q <= '0;
      end else begin
         up_q <= up_d;
         dn_q <= dn_d;
      end
   end

endmodule

// File: rtl/bw_io_impctl_ddr_dncal_fsm.sv
// Pull-down impedance calibration sequencer: SAR search for the
// initial code, then optional filtered +/-1 drift tracking.
module bw_io_impctl_ddr_dncal_fsm
   import bw_io_impctl_defs::*;
#(
   parameter int WIDTH      = 8,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int SAMPLE_LAT = SAMPLE_LAT_DEF,
   parameter int FILT_N     = FILT_N_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic cal_start,
   input  logic track_en,
   output logic busy,
   output logic cal_done,
   output logic code_vld,
   output logic sat_hi,
   output logic sat_lo,
   bw_io_impctl_ddr_dncal_fsm_if.master slc
);

   localparam int PW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
   localparam int CMAX = (SETTLE_CYC > SAMPLE_LAT) ? SETTLE_CYC
                                                    : SAMPLE_LAT;
   localparam int CW = cnt_w(CMAX);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] cbd_q, cbd_d;
   logic             done_q, done_d;
   logic             vld_q, vld_d;
   logic             sat_hi_q, sat_hi_d;
   logic             sat_lo_q, sat_lo_d;

   logic             filt_clr;
   logic             filt_stb;
   logic             step_up;
   logic             step_dn;

   assign filt_clr = (state_q == ST_IDLE) && cal_start;
   assign filt_stb = (state_q == ST_DECIDE) && (mode_q == MODE_TRACK);

   bw_io_impctl_updn_filt #(
      .FILT_N (FILT_N)
   ) u_filt (
      .clk        (clk),
      .reset      (reset),
      .clr        (filt_clr),
      .sample_stb (filt_stb),
      .above      (slc.above),
      .step_up    (step_up),
      .step_dn    (step_dn)
   );

   // Next-state and datapath: settle, strobe, wait, then decide.
   always_comb begin
      logic [WIDTH-1:0] trial;
      logic [PW-1:0]    nxt_ptr;

      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      cbd_d    = cbd_q;
      done_d   = 1'b0;
      vld_d    = vld_q;
      sat_hi_d = sat_hi_q;
      sat_lo_d = sat_lo_q;
      trial    = cbd_q;
      nxt_ptr  = ptr_q - PW'(1);

      unique case (state_q)
         ST_IDLE: begin
            if (cal_start) begin
               vld_d    = 1'b0;
               sat_hi_d = 1'b0;
               sat_lo_d = 1'b0;
               cbd_d    = {1'b1, {(WIDTH-1){1'b0}}};
               ptr_d    = PW'(WIDTH - 1);
               mode_d   = MODE_SAR;
               cnt_d    = '0;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYC - 1)) begin
               cnt_d   = '0;
               state_d = ST_STROBE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STROBE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == CW'(SAMPLE_LAT - 1)) begin
               cnt_d   = '0;
               state_d = ST_DECIDE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DECIDE: begin
            if (mode_q == MODE_SAR) begin
               if (!slc.above) begin
                  trial[ptr_q] = 1'b0;
               end
               if (ptr_q != '0) begin
                  trial[nxt_ptr] = 1'b1;
                  ptr_d          = nxt_ptr;
                  state_d        = ST_SETTLE;
               end else begin
                  done_d   = 1'b1;
                  vld_d    = 1'b1;
                  sat_hi_d = (&trial) && slc.above;
                  sat_lo_d = (~|trial) && !slc.above;
                  state_d  = ST_TRACK_CHK;
               end
               cbd_d = trial;
            end else begin
               if (step_up) begin
                  if (&cbd_q) begin
                     sat_hi_d = 1'b1;
                  end else begin
                     cbd_d    = cbd_q + WIDTH'(1);
                     sat_hi_d = 1'b0;
                     sat_lo_d = 1'b0;
                  end
               end else if (step_dn) begin
                  if (cbd_q == '0) begin
                     sat_lo_d = 1'b1;
                  end else begin
                     cbd_d    = cbd_q - WIDTH'(1);
                     sat_hi_d = 1'b0;
                     sat_lo_d = 1'b0;
                  end
               end
               state_d = ST_TRACK_CHK;
            end
         end
         ST_TRACK_CHK: begin
            if (track_en) begin
               mode_d  = MODE_TRACK;
               // This cycle already counts as settle time for
               // the code, keeping a tracking sample the same
               // length as a SAR bit.
               cnt_d   = CW'(1);
               state_d = ST_SETTLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         mode_q   <= MODE_SAR;
         cnt_q    <= '0;
         ptr_q    <= '0;
         cbd_q    <= '0;
         done_q   <= 1'b0;
         vld_q    <= 1'b0;
         sat_hi_q <= 1'b0;
         sat_lo_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         cbd_q    <= cbd_d;
         done_q   <= done_d;
         vld_q    <= vld_d;
         sat_hi_q <= sat_hi_d;
         sat_lo_q <= sat_lo_d;
      end
   end

   assign slc.cbd  = cbd_q;
   assign slc.oe   = (state_q != ST_IDLE);
   assign slc.sclk = (state_q == ST_STROBE);
   assign busy     = (state_q != ST_IDLE);
   assign cal_done = done_q;
   assign code_vld = vld_q;
   assign sat_hi   = sat_hi_q;
   assign sat_lo   = sat_lo_q;

endmodule

// File: tb/tb_bw_io_impctl_ddr_dncal_fsm.sv
// Directed bench for the pull-down calibration sequencer
// with a simple threshold model of the comparator slice.
module tb_bw_io_impctl_ddr_dncal_fsm;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cal_start = 1'b0;
   logic track_en = 1'b0;
   logic busy, cal_done, code_vld, sat_hi, sat_lo;

   bw_io_impctl_ddr_dncal_fsm_if #(.WIDTH(8)) slc ();

   bw_io_impctl_ddr_dncal_fsm dut (
      .clk       (clk),
      .reset     (reset),
      .cal_start (cal_start),
      .track_en  (track_en),
      .busy      (busy),
      .cal_done  (cal_done),
      .code_vld  (code_vld),
      .sat_hi    (sat_hi),
      .sat_lo    (sat_lo),
      .slc       (slc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int sclk_cnt = 0;
   int n_cmp = 0;
   int n_err = 0;

   // model: 0 threshold, 1 always above, 2 never, 3 alternate
   int mode = 0;
   logic [8:0] thr = 9'h05C;
   int alt_base = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (slc.sclk) sclk_cnt <= sclk_cnt + 1;

   always_comb begin
      case (mode)
         0: slc.above = ({1'b0, slc.cbd} < thr);
         1: slc.above = 1'b1;
         2: slc.above = 1'b0;
         default: slc.above = ((sclk_cnt - alt_base) % 2) == 1;
      endcase
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_cal(output int c0);
      @(negedge clk) cal_start = 1'b1;
      @(negedge clk) cal_start = 1'b0;
      c0 = cyc - 1;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!cal_done && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(cal_done), 1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(busy), 0);
   endtask

   task automatic wait_sclk(input string tag, input int n);
      int s0 = sclk_cnt;
      int k = 0;
      while ((sclk_cnt - s0) < n && k < n * 21 + 50) begin
         @(negedge clk);
         k++;
      end
      chk(tag, sclk_cnt - s0, n);
   endtask

   task automatic wait_cyc(input int c0, input int n);
      int k = 0;
      while ((cyc - c0) < n && k < 1000) begin
         @(negedge clk);
         k++;
      end
   endtask

   logic [7:0] trk_exp [8] = '{8'h5C, 8'h5D, 8'h5E, 8'h5F,
                               8'h60, 8'h5F, 8'h60, 8'h5F};

   initial begin
      int c0, s0, t0, k;
      logic [7:0] prev;

      // reset values, cal_start together with reset is ignored
      tick(3);
      cal_start = 1'b1;
      tick(1);
      chk("rst_cbd", 32'(slc.cbd), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_oe", 32'(slc.oe), 0);
      chk("rst_sclk", 32'(slc.sclk), 0);
      chk("rst_flags", 32'({cal_done, code_vld, sat_hi, sat_lo}), 0);
      reset = 1'b0;
      cal_start = 1'b0;
      tick(2);
      chk("rst_start_ign", 32'(busy), 0);

      // SAR search to threshold 0x5C
      mode = 0;
      thr = 9'h05C;
      s0 = sclk_cnt;
      start_cal(c0);
      chk("sar_busy", 32'(busy), 1);
      wait_done("sar_done");
      chk("sar_done_cyc", cyc - c0, 169);
      chk("sar_cbd", 32'(slc.cbd), 'h5B);
      chk("sar_vld", 32'(code_vld), 1);
      chk("sar_sat", 32'({sat_hi, sat_lo}), 0);
      chk("sar_sclk_n", sclk_cnt - s0, 8);
      tick(1);
      chk("sar_pulse", 32'(cal_done), 0);
      chk("sar_idle", 32'(busy), 0);
      chk("sar_oe", 32'(slc.oe), 0);

      // saturation high, tracking must not wrap
      mode = 1;
      track_en = 1'b1;
      start_cal(c0);
      wait_done("sath_done");
      chk("sath_cbd", 32'(slc.cbd), 'hFF);
      chk("sath_flag", 32'({sat_hi, sat_lo}), 2);
      tick(200);
      chk("sath_trk_cbd", 32'(slc.cbd), 'hFF);
      chk("sath_trk_flag", 32'(sat_hi), 1);
      track_en = 1'b0;
      wait_idle("sath_idle");

      // saturation low, tracking must not wrap
      mode = 2;
      track_en = 1'b1;
      start_cal(c0);
      wait_done("satl_done");
      chk("satl_cbd", 32'(slc.cbd), 'h00);
      chk("satl_flag", 32'({sat_hi, sat_lo}), 1);
      tick(200);
      chk("satl_trk_cbd", 32'(slc.cbd), 'h00);
      chk("satl_trk_flag", 32'(sat_lo), 1);
      track_en = 1'b0;
      wait_idle("satl_idle");

      // tracking toward threshold 0x60, then dithering
      mode = 0;
      thr = 9'h05C;
      track_en = 1'b1;
      start_cal(c0);
      wait_done("trk_done");
      chk("trk_sar_cbd", 32'(slc.cbd), 'h5B);
      thr = 9'h060;
      prev = slc.cbd;
      t0 = cyc;
      for (int i = 0; i < 8; i++) begin
         k = 0;
         while (slc.cbd == prev && k < 200) begin
            @(negedge clk);
            k++;
         end
         chk($sformatf("trk_cbd%0d", i), 32'(slc.cbd), 32'(trk_exp[i]));
         chk($sformatf("trk_dt%0d", i), cyc - t0, 84);
         prev = slc.cbd;
         t0 = cyc;
      end

      // alternating samples never step
      alt_base = sclk_cnt;
      mode = 3;
      wait_sclk("alt_sclk", 20);
      tick(6);
      chk("alt_cbd", 32'(slc.cbd), 'h5F);

      // drop track_en in WAIT of the stepping sample
      mode = 1;
      wait_sclk("drop_sclk", 4);
      track_en = 1'b0;
      wait_idle("drop_idle");
      chk("drop_cbd", 32'(slc.cbd), 'h60);
      chk("drop_oe", 32'(slc.oe), 0);
      s0 = sclk_cnt;
      tick(100);
      chk("drop_hold", 32'(slc.cbd), 'h60);
      chk("drop_nosclk", sclk_cnt - s0, 0);

      // ignored cal_start while busy, then reset in bit 4
      mode = 0;
      thr = 9'h05C;
      s0 = sclk_cnt;
      start_cal(c0);
      wait_cyc(c0, 29);
      cal_start = 1'b1;
      tick(1);
      cal_start = 1'b0;
      wait_cyc(c0, 70);
      chk("ign_cbd", 32'(slc.cbd), 'h50);
      chk("ign_sclk", sclk_cnt - s0, 3);
      wait_cyc(c0, 75);
      reset = 1'b1;
      tick(1);
      chk("mid_rst_cbd", 32'(slc.cbd), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_oe", 32'(slc.oe), 0);
      chk("mid_rst_vld", 32'(code_vld), 0);
      reset = 1'b0;
      s0 = sclk_cnt;
      tick(300);
      chk("post_rst_sclk", sclk_cnt - s0, 0);
      chk("post_rst_busy", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
